// File: rtl/arbiter_x4.sv
// Four-requester round-robin arbiter with a rotating priority pointer and a
// hold-limit timeout that preempts an owner while others are waiting.
module arbiter_x4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] z,
  output logic       y
);

  // state | meaning
  // IDLE  | no owner, gnt/y low, z keeps the last owner index
  // BUSY  | owner is z; held until release or hold-limit preemption
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("arbiter_x4: MAX_HOLD must be in 2..255");
    end
  endgenerate

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] z_nxt;
  logic       y_nxt;
  logic [3:0] owner_bit;
  logic [3:0] others;
  logic [1:0] z_inc;
  logic [2:0] pick_new;
  logic [2:0] pick_hand;

  // Returns {found, index}; the lowest rotational offset from p wins.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    owner_bit = 4'b0001 << z;
    others    = req & ~owner_bit;
    z_inc     = z + 2'd1;
    pick_new  = pick(req, ptr);
    pick_hand = pick(others, z_inc);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    z_nxt     = z;
    unique case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (pick_new[2]) begin
          state_nxt = BUSY;
          z_nxt     = pick_new[1:0];
          gnt_nxt   = 4'b0001 << pick_new[1:0];
          cnt_nxt   = 8'd0;
        end
      end
      BUSY: begin
        if (!req[z]) begin
          ptr_nxt = z_inc;
          if (pick_hand[2]) begin
            z_nxt   = pick_hand[1:0];
            gnt_nxt = 4'b0001 << pick_hand[1:0];
            cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else if (cnt == HOLD_LAST && pick_hand[2]) begin
          // Timeout with contention: rotate past the owner, who stays eligible later.
          ptr_nxt = z_inc;
          z_nxt   = pick_hand[1:0];
          gnt_nxt = 4'b0001 << pick_hand[1:0];
          cnt_nxt = 8'd0;
        end else if (cnt != HOLD_LAST) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
    y_nxt = |gnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
      gnt   <= 4'b0000;
      z     <= 2'd0;
      y     <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      z     <= z_nxt;
      y     <= y_nxt;
    end
  end

endmodule
